// File: rtl/ones_count_unit.sv
// ============================================================================
// Module   : ones_count_unit
// Brief    : start/rdy sequenced popcount engine (shift-into-E, count on E=1)
// Revision : 1.0
// ============================================================================
`default_nettype none

module ones_count_unit #(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  data_in,
  output logic          rdy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SHIFT = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q;
  logic [W-1:0]    r1_q;
  logic            e_q;
  logic [CW-1:0]   r2_q;
  logic            rdy_q;
  logic            done_q;

  // rdy/done are registered alongside the state so they decode it exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r1_q    <= '0;
      e_q     <= 1'b0;
      r2_q    <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            r1_q    <= data_in;
            r2_q    <= '0;
            e_q     <= 1'b0;
            state_q <= S_CHECK;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        S_CHECK: begin
          if (r1_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {e_q, r1_q} <= {r1_q, 1'b0};
          state_q     <= S_EVAL;
        end
        S_EVAL: begin
          // E=0 implies a set bit remains below, so CHECK can be skipped
          if (e_q) begin
            r2_q    <= r2_q + CW'(1);
            state_q <= S_CHECK;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy   = rdy_q;
  assign done  = done_q;
  assign count = r2_q;

endmodule

`default_nettype wire

// File: tb/tb_ones_count_unit.sv
// ============================================================================
// Module   : tb_ones_count_unit
// Brief    : directed bench for ones_count_unit with a per-cycle reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ones_count_unit;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic          rdy;
  logic          done;
  logic [CW-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  ones_count_unit #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .rdy     (rdy),
    .done    (done),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [W-1:0] d);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(d[i]);
    return c;
  endfunction

  // Edge number (after the accepting edge) at which DONE is entered
  function automatic int exp_lat(input logic [W-1:0] d);
    int low = 0;
    if (d == '0) return 1;
    while (d[low] == 1'b0) low++;
    return 1 + 2 * (W - low) + popc(d);
  endfunction

  // Reference model: phase 0 idle, 1 busy, 2 done-cycle
  int m_phase = 0;
  int m_k     = 0;
  int m_lat   = 0;
  int m_res   = 0;
  int m_cnt   = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      chk_en  = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_lat   = exp_lat(data_in);
             m_res   = popc(data_in);
             m_k     = 0;
             m_phase = 1;
           end
        1: begin
             m_k++;
             if (m_k == m_lat) begin
               m_phase = 2;
               m_cnt   = m_res;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rdy", int'(rdy), int'(m_phase == 0));
      chk("model_done", int'(done), int'(m_phase == 2));
      if (m_phase != 1) chk("model_count", int'(count), m_cnt);
    end
  end

  // Wait for done after the accepting edge has passed; returns the DONE edge index
  task automatic wait_done(input string name, output int lat);
    int e = 1;
    while (!done && e < 200) begin
      @(negedge clk);
      e++;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
    lat = e - 1;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] d,
                        input int exp_cnt, input int exp_l);
    int lat;
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'h5A;
    wait_done(name, lat);
    chk({name, "_count"}, int'(count), exp_cnt);
    chk({name, "_lat"}, lat, exp_l);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int b;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rdy", int'(rdy), 1);
      chk("idle_done", int'(done), 0);
      chk("idle_count", int'(count), 0);
    end

    run_op("zero", 8'h00, 0, 1);
    chk("zero_rdy_after", int'(rdy), 1);
    run_op("op80", 8'h80, 1, 4);
    run_op("op01", 8'h01, 1, 18);
    run_op("opFF", 8'hFF, 8, 25);
    run_op("opA5", 8'hA5, 4, 21);

    // Start pulses while busy are ignored; held start is taken after DONE
    start   = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 200) begin
      start   = lat[0];
      data_in = 8'h00;
      @(negedge clk);
      lat++;
    end
    chk("busy_lat", lat - 1, 25);
    chk("busy_count", int'(count), 8);
    start   = 1'b1;
    data_in = 8'h03;
    @(negedge clk);
    chk("busy_idle_rdy", int'(rdy), 1);
    @(negedge clk);
    start = 1'b0;
    wait_done("held03", lat);
    chk("held03_count", int'(count), 2);
    chk("held03_lat", lat, 19);
    @(negedge clk);

    // Reset mid-operation once three ones have been counted
    start   = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (count != 3 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("midrst_reach3", int'(count), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rdy", int'(rdy), 1);
    chk("midrst_count", int'(count), 0);
    chk("midrst_done", int'(done), 0);
    run_op("op0F", 8'h0F, 4, 21);

    // Sweep every operand back-to-back with start held high
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data_in = 8'(i);
      b = 0;
      while (!rdy && b < 10) begin
        @(negedge clk);
        b++;
      end
      @(negedge clk);
      data_in = 8'($urandom);
      wait_done("sweep", lat);
      chk("sweep_count", int'(count), $countones(8'(i)));
      chk("sweep_lat", lat, exp_lat(8'(i)));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
